// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared width default and FSM state type for the CODEC responder
package codec_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    HOLD,
    SYNC,
    RUN
  } codec_st_t;

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - single-register rise/fall detector for a clk-synchronous input
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/codec_resp.sv
// rtl/codec_resp.sv - CODEC-side serial audio responder: deserializes SDin, serializes SDout
module codec_resp #(
  parameter int DATA_W = codec_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LRCLK,
  input  logic              SCLK,
  input  logic              RSTn,
  input  logic              SDin,
  output logic              SDout,
  input  logic [DATA_W-1:0] lft_tx,
  input  logic [DATA_W-1:0] rht_tx,
  output logic [DATA_W-1:0] lft_rx,
  output logic [DATA_W-1:0] rht_rx,
  output logic              rx_valid,
  output logic              frame_err
);

  import codec_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);

  codec_st_t          state, state_nxt;
  logic               lr_rise, lr_fall, sc_rise, sc_fall, lr_edge;
  logic               tx_active, rx_active;
  logic [DATA_W-1:0]  rht_hold, tx_shft, rx_shft;
  logic [CNT_W-1:0]   bit_cnt;

  edge_det u_lr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (LRCLK),
    .rise  (lr_rise),
    .fall  (lr_fall)
  );

  edge_det u_sc_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (SCLK),
    .rise  (sc_rise),
    .fall  (sc_fall)
  );

  assign lr_edge = lr_rise | lr_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HOLD;
    else        state <= state_nxt;
  end

  // RSTn low overrides everything in the same cycle, so nothing is captured or sent while it is low.
  always_comb begin
    state_nxt = state;
    tx_active = 1'b0;
    rx_active = 1'b0;
    if (!RSTn) begin
      state_nxt = HOLD;
    end else begin
      case (state)
        HOLD: state_nxt = SYNC;
        SYNC: begin
          tx_active = 1'b1;
          if (lr_rise) state_nxt = RUN;
        end
        RUN: begin
          tx_active = 1'b1;
          rx_active = 1'b1;
        end
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rht_hold <= '0;
      tx_shft  <= '0;
    end else if (!tx_active) begin
      rht_hold <= '0;
      tx_shft  <= '0;
    end else if (lr_rise) begin
      rht_hold <= rht_tx;
      tx_shft  <= lft_tx;
    end else if (lr_fall) begin
      tx_shft  <= rht_hold;
    end else if (sc_fall) begin
      tx_shft  <= {tx_shft[DATA_W-2:0], 1'b0};
    end
  end

  assign SDout = tx_shft[DATA_W-1];

  // A bit arriving on the same cycle as an LRCLK edge is dropped; the capture sees the pre-shift word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft   <= '0;
      bit_cnt   <= '0;
      lft_rx    <= '0;
      rht_rx    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_active) begin
        rx_shft <= '0;
        bit_cnt <= '0;
      end else if (lr_edge) begin
        bit_cnt <= '0;
        if (bit_cnt != CNT_W'(DATA_W)) frame_err <= 1'b1;
        if (lr_fall) begin
          lft_rx <= rx_shft;
        end else begin
          rht_rx   <= rx_shft;
          rx_valid <= 1'b1;
        end
      end else if (sc_rise) begin
        rx_shft <= {rx_shft[DATA_W-2:0], SDin};
        if (bit_cnt != CNT_W'(DATA_W)) bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_codec_resp.sv
// tb/tb_codec_resp.sv - directed bench: behavioural link master driving codec_resp
module tb_codec_resp;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, LRCLK, SCLK, RSTn, SDin, SDout;
  logic [W-1:0] lft_tx, rht_tx, lft_rx, rht_rx;
  logic         rx_valid, frame_err;

  codec_resp #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .LRCLK     (LRCLK),
    .SCLK      (SCLK),
    .RSTn      (RSTn),
    .SDin      (SDin),
    .SDout     (SDout),
    .lft_tx    (lft_tx),
    .rht_tx    (rht_tx),
    .lft_rx    (lft_rx),
    .rht_rx    (rht_rx),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] lft_out, rht_out, m_shft, m_lft_in, m_rht_in;
  logic [W-1:0] lft_prev, rht_prev;
  logic [9:0]   pos;
  int           half_len;
  bit           short_next, master_on;
  int           cyc, vcnt, vhi, last_v, bad_gap, sd_bad, guard;
  logic         prev_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Master: SCLK period 32 clk, data changes on SCLK fall, SDout sampled on SCLK rise.
  task automatic tick();
    int b;
    @(posedge clk);
    #1;
    cyc++;
    if (SDout !== 1'b0) sd_bad++;
    if (rx_valid === 1'b1) begin
      vhi++;
      if (prev_v !== 1'b1) begin
        vcnt++;
        if (last_v >= 0 && (cyc - last_v) != 1024) bad_gap++;
        last_v = cyc;
      end
    end
    prev_v = rx_valid;
    if (master_on) begin
      pos = pos + 10'd1;
      if (int'(pos) == half_len) begin
        if (LRCLK) m_lft_in = m_shft;
        else       m_rht_in = m_shft;
        pos      = '0;
        LRCLK    = ~LRCLK;
        half_len = short_next ? 480 : 512;
        short_next = 1'b0;
      end
      if (pos[4:0] == 5'd16) m_shft = {m_shft[W-2:0], SDout};
      SCLK = pos[4];
      b    = 15 - int'(pos[8:5]);
      SDin = LRCLK ? lft_out[b] : rht_out[b];
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0; RSTn = 1'b0; LRCLK = 1'b0; SCLK = 1'b0; SDin = 1'b0;
    lft_out = 16'hA5C3; rht_out = 16'h0F0F; lft_tx = 16'h1234; rht_tx = 16'h8001;
    m_shft = '0; m_lft_in = '0; m_rht_in = '0;
    pos = '0; half_len = 512; short_next = 1'b0; master_on = 1'b0;
    cyc = 0; vcnt = 0; vhi = 0; last_v = -1; bad_gap = 0; sd_bad = 0; prev_v = 1'b0;

    run(3);
    check("rst_sdout", SDout, 0);
    check("rst_lft_rx", lft_rx, 0);
    check("rst_rht_rx", rht_rx, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);

    // rst_n released, RSTn still low: link runs but responder stays silent
    rst_n = 1'b1;
    master_on = 1'b1;
    sd_bad = 0;
    run(1024 + 256);
    check("hold_sdout", sd_bad, 0);
    check("hold_valid", vcnt, 0);
    check("hold_lft_rx", lft_rx, 0);
    check("hold_frame_err", frame_err, 0);

    // RSTn rises mid right half; first rise only syncs
    RSTn = 1'b1;
    sd_bad = 0;
    run(256);
    check("sync_sdout", sd_bad, 0);
    vcnt = 0;
    run(600);
    check("first_rise_no_valid", vcnt, 0);
    run(428);
    check("second_rise_valid", vcnt, 1);
    check("lb_lft_rx", lft_rx, 16'hA5C3);
    check("lb_rht_rx", rht_rx, 16'h0F0F);
    check("lb_m_lft_in", m_lft_in, 16'h1234);
    check("lb_m_rht_in", m_rht_in, 16'h8001);
    check("lb_frame_err", frame_err, 0);

    // free-running: 10 frames, 10 single-cycle pulses 1024 clk apart
    vcnt = 0; vhi = 0; last_v = -1; bad_gap = 0;
    run(10 * 1024);
    check("ten_pulses", vcnt, 10);
    check("ten_pulse_width", vhi, 10);
    check("ten_spacing", bad_gap, 0);

    // second data pattern
    lft_out = 16'h0001; rht_out = 16'hFFFE; lft_tx = 16'hC0DE; rht_tx = 16'h7F80;
    run(3 * 1024);
    check("p2_lft_rx", lft_rx, 16'h0001);
    check("p2_rht_rx", rht_rx, 16'hFFFE);
    check("p2_m_lft_in", m_lft_in, 16'hC0DE);
    check("p2_m_rht_in", m_rht_in, 16'h7F80);
    check("p2_frame_err", frame_err, 0);

    // one right half with only 15 SCLK periods
    short_next = 1'b1;
    run(1024);
    check("short_frame_err", frame_err, 1);
    run(2 * 1024);
    check("short_err_sticky", frame_err, 1);
    check("short_after_lft_rx", lft_rx, 16'h0001);
    check("short_after_rht_rx", rht_rx, 16'hFFFE);

    // drop RSTn after bit 7 of the left word
    lft_tx = 16'hFFFF; rht_tx = 16'hFFFF;
    guard = 0;
    while (LRCLK !== 1'b0 && guard < 2048) begin tick(); guard++; end
    while (!(LRCLK === 1'b1 && pos == 10'd250) && guard < 4096) begin tick(); guard++; end
    check("drop_sync_wait", guard < 4096, 1);
    check("drop_sdout_before", SDout, 1);
    lft_prev = lft_rx; rht_prev = rht_rx;
    RSTn = 1'b0;
    tick();
    check("drop_sdout_after", SDout, 0);
    sd_bad = 0; vcnt = 0;
    run(1024);
    check("drop_sdout_quiet", sd_bad, 0);
    check("drop_no_valid", vcnt, 0);
    check("drop_lft_keep", lft_rx, lft_prev);
    check("drop_rht_keep", rht_rx, rht_prev);
    check("drop_lft_val", lft_rx, 16'h0001);
    check("drop_err_keep", frame_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
